vjtag_ram_reader: RTL

VJTAG_RAM_READER -- requirements
Module: vjtag_ram_reader

---
 rtl/vjtag_pkg.sv | 22 ++
 rtl/vjtag_dr_shift.sv | 36 +++
 rtl/vjtag_ram_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vjtag_pkg.sv
// vjtag_ram_reader shared types: IR codes, prefetch states, sizing helper.
// Optional feature macro: VJTAG_RD_PARITY_EN (parity bit on READ DR).
package vjtag_pkg;

  typedef enum logic [1:0] {
    IR_BYPASS   = 2'b00,
    IR_SET_ADDR = 2'b01,
    IR_READ     = 2'b10,
    IR_STATUS   = 2'b11
  } ir_e;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'b00,
    PF_FETCH = 2'b01,
    PF_LATCH = 2'b10
  } pf_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vjtag_dr_shift.sv
// Shared capture/shift data register; tdi enters at the active length's MSB.
// Length is selected by a one-hot MSB mask so one register serves all DRs.
import vjtag_pkg::*;

module vjtag_dr_shift #(
  parameter int W = 9
) (
  input  logic         tck,
  input  logic         aclr,
  input  logic         cap_en,
  input  logic [W-1:0] cap_val,
  input  logic         sh_en,
  input  logic [W-1:0] msb,
  input  logic         tdi,
  output logic [W-1:0] q
);

  logic [W-1:0] sh_nxt;

  // right shift, new bit lands at the selected MSB position
  always_comb begin
    sh_nxt = ((q >> 1) & ~msb) | ({W{tdi}} & msb);
  end

  // capture has priority over shift
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      q <= '0;
    end else if (cap_en) begin
      q <= cap_val;
    end else if (sh_en) begin
      q <= sh_nxt;
    end
  end

endmodule

// File: rtl/vjtag_ram_reader.sv
// Virtual-JTAG RAM reader: address pointer, 1-word prefetch, shared DR.
// Optional feature macro: VJTAG_RD_PARITY_EN (READ DR gains even parity MSB).
import vjtag_pkg::*;

module vjtag_ram_reader #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          tck,
  input  logic          aclr,
  input  logic [1:0]    ir_in,
  input  logic          v_cdr,
  input  logic          v_sdr,
  input  logic          v_udr,
  input  logic          tdi,
  output logic          tdo,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rden,
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] cur_addr
);

`ifdef VJTAG_RD_PARITY_EN
  localparam int RDW = DW + 1;
`else
  localparam int RDW = DW;
`endif
  localparam int SW = max2(AW + 1, DW + 1);

  ir_e ir;
  assign ir = ir_e'(ir_in);

  pf_state_e     state;
  pf_state_e     state_nxt;
  logic [AW-1:0] ptr;
  logic [DW-1:0] pf_data;
  logic          pf_valid;
  logic          boot;
  logic          byp;
  logic [SW-1:0] sr;
  logic [SW-1:0] cap_val;
  logic [SW-1:0] msb;

  logic cap;
  logic upd;
  logic shf;
  logic ptr_chg;
  logic fwd;
  logic [DW-1:0] cap_data;
  logic cap_valid;
  logic [RDW-1:0] rd_word;

  // TAP flag priority: capture, then update, then shift
  always_comb begin
    cap     = v_cdr;
    upd     = v_udr & ~v_cdr;
    shf     = v_sdr & ~v_cdr & ~v_udr;
    ptr_chg = upd & ((ir == IR_SET_ADDR) | (ir == IR_READ));
  end

  // a capture landing on the LATCH edge takes ram_q directly
  always_comb begin
    fwd       = (state == PF_LATCH);
    cap_data  = fwd ? ram_q : pf_data;
    cap_valid = pf_valid | fwd;
  end

`ifdef VJTAG_RD_PARITY_EN
  // even parity over the data word, placed above it
  always_comb begin
    rd_word = {^cap_data, cap_data};
  end
`else
  // plain data word
  always_comb begin
    rd_word = cap_data;
  end
`endif

  // capture value and active DR length per IR
  always_comb begin
    cap_val = '0;
    msb     = '0;
    unique case (ir)
      IR_SET_ADDR: begin
        cap_val[AW-1:0] = ptr;
        msb[AW-1]       = 1'b1;
      end
      IR_READ: begin
        cap_val[RDW-1:0] = rd_word;
        msb[RDW-1]       = 1'b1;
      end
      IR_STATUS: begin
        cap_val[AW:0] = {cap_valid, ptr};
        msb[AW]       = 1'b1;
      end
      IR_BYPASS: begin
        msb[0] = 1'b1;
      end
    endcase
  end

  vjtag_dr_shift #(
    .W(SW)
  ) u_dr (
    .tck    (tck),
    .aclr   (aclr),
    .cap_en (cap & (ir != IR_BYPASS)),
    .cap_val(cap_val),
    .sh_en  (shf & (ir != IR_BYPASS)),
    .msb    (msb),
    .tdi    (tdi),
    .q      (sr)
  );

  // 1-bit bypass register
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      byp <= 1'b0;
    end else if (cap & (ir == IR_BYPASS)) begin
      byp <= 1'b0;
    end else if (shf & (ir == IR_BYPASS)) begin
      byp <= tdi;
    end
  end

  // read pointer: load on SET_ADDR update, advance on READ update
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      ptr <= '0;
    end else if (upd & (ir == IR_SET_ADDR)) begin
      ptr <= sr[AW-1:0];
    end else if (upd & (ir == IR_READ)) begin
      ptr <= ptr + AW'(1);
    end
  end

  // one-shot flag that kicks the first prefetch after reset
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      boot <= 1'b1;
    end else begin
      boot <= 1'b0;
    end
  end

  // prefetch state register
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      state <= PF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // prefetch next state and RAM strobe
  always_comb begin
    state_nxt = state;
    ram_rden  = 1'b0;
    unique case (state)
      PF_IDLE: begin
        if (ptr_chg | boot) state_nxt = PF_FETCH;
      end
      PF_FETCH: begin
        ram_rden  = 1'b1;
        state_nxt = ptr_chg ? PF_FETCH : PF_LATCH;
      end
      PF_LATCH: begin
        state_nxt = ptr_chg ? PF_FETCH : PF_IDLE;
      end
      default: begin
        state_nxt = PF_IDLE;
      end
    endcase
  end

  // prefetch data and valid; stale on any pointer move
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      pf_data  <= '0;
      pf_valid <= 1'b0;
    end else if (ptr_chg | (state == PF_FETCH)) begin
      pf_valid <= 1'b0;
    end else if (state == PF_LATCH) begin
      pf_data  <= ram_q;
      pf_valid <= 1'b1;
    end
  end

  logic unused_sr;
  assign unused_sr = ^sr[SW-1:AW];

  assign tdo      = (ir == IR_BYPASS) ? byp : sr[0];
  assign ram_addr = ptr;
  assign cur_addr = ptr;

endmodule
